axi_lite_master_ctrl: RTL and testbench

//  Single-outstanding AXI4-Lite master. Sits directly upstream of the byte-memory AXI-Lite slave.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_watchdog.sv | 41 ++++
 rtl/axi_lite_master_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_master_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes and the
// one-hot FSM state encoding used by axi_lite_master_ctrl.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_WR_REQ  = 6'b000010,
        S_WR_RESP = 6'b000100,
        S_RD_REQ  = 6'b001000,
        S_RD_RESP = 6'b010000,
        S_RSP     = 6'b100000
    } state_e;

    // States in which the transaction waits on the slave (watchdog runs).
    function automatic logic is_wait_state(state_e s);
        return (s == S_WR_REQ) || (s == S_WR_RESP) ||
               (s == S_RD_REQ) || (s == S_RD_RESP);
    endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Per-state watchdog counter.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : clear counter (asserted on the edge that enters a new state)
//   en_i          : count this cycle
//   expire_o      : this is the TIMEOUT-th cycle in the current state; the
//                   owner aborts on the closing edge. Never asserts if TIMEOUT==0.
module axi_lite_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;

    // Saturating counter: it holds at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            // cnt_q counts completed cycles in the state, so TIMEOUT-1 means
            // the current cycle is the TIMEOUT-th one.
            assign expire_o = en_i && (cnt_q >= CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master with per-state watchdog.
//   ACLK/ARESETN          : clock, async active-low reset
//   cmd_*                 : request from local logic (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                 : response to local logic (valid/ready, rdata, resp, timeout)
//   AW*/W*/B*/AR*/R*      : AXI4-Lite master channels
// Every output comes straight from a flop.
module axi_lite_master_ctrl
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              WVALID,
    input  logic              WREADY,
    output logic [31:0]       WDATA,
    output logic [3:0]        WSTRB,
    input  logic              BVALID,
    output logic              BREADY,
    input  logic [1:0]        BRESP,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP
);

    state_e            state_q;
    logic              cmd_ready_q, rsp_valid_q, rsp_timeout_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_resp_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_req_done;
    logic wd_expire, leave;

    assign cmd_hs = cmd_valid & cmd_ready_q;
    assign rsp_hs = rsp_valid_q & rsp_ready;
    assign aw_hs  = awvalid_q & AWREADY;
    assign w_hs   = wvalid_q & WREADY;
    assign b_hs   = BVALID & bready_q;
    assign ar_hs  = arvalid_q & ARREADY;
    assign r_hs   = RVALID & rready_q;

    // AW and W complete independently; each is done once its valid has
    // dropped or is handshaking this cycle.
    assign wr_req_done = (aw_hs | ~awvalid_q) & (w_hs | ~wvalid_q);

    // Any state exit; used to clear the watchdog so every state starts at 0.
    always_comb begin
        leave = 1'b0;
        case (state_q)
            S_IDLE:    leave = cmd_hs;
            S_WR_REQ:  leave = wr_req_done | wd_expire;
            S_WR_RESP: leave = b_hs | wd_expire;
            S_RD_REQ:  leave = ar_hs | wd_expire;
            S_RD_RESP: leave = r_hs | wd_expire;
            S_RSP:     leave = rsp_hs;
            default:   leave = 1'b1;
        endcase
    end

    axi_lite_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wd (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .clr_i    (leave),
        .en_i     (is_wait_state(state_q)),
        .expire_o (wd_expire)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_REQ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (wr_req_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end else if (wd_expire) begin
                        awvalid_q     <= 1'b0;
                        wvalid_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= RESP_SLVERR;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RSP;
                    end
                end
                S_WR_RESP: begin
                    if (b_hs || wd_expire) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= ~b_hs;
                        rsp_resp_q    <= b_hs ? BRESP : RESP_SLVERR;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_RESP;
                    end else if (wd_expire) begin
                        arvalid_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= RESP_SLVERR;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RSP;
                    end
                end
                S_RD_RESP: begin
                    if (r_hs || wd_expire) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= ~r_hs;
                        rsp_resp_q    <= r_hs ? RRESP : RESP_SLVERR;
                        rsp_rdata_q   <= r_hs ? RDATA : 32'h0;
                        state_q       <= S_RSP;
                    end
                end
                S_RSP: begin
                    // Requester stalls here are not timed.
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign AWVALID     = awvalid_q;
    assign AWADDR      = addr_q;
    assign WVALID      = wvalid_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = wstrb_q;
    assign BREADY      = bready_q;
    assign ARVALID     = arvalid_q;
    assign ARADDR      = addr_q;
    assign RREADY      = rready_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Bench for axi_lite_master_ctrl: byte-memory AXI-Lite slave with
// controllable readies, plus a reference byte array that predicts responses.
module tb_axi_lite_master_ctrl;

    localparam int ADDR_W = 32;
    localparam int TMO    = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [31:0]       WDATA, RDATA;
    logic [3:0]        WSTRB;
    logic [1:0]        BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi_lite_master_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    // ---------------- slave model ----------------
    logic       aw_rdy, w_rdy, ar_rdy, r_block, rand_rdy;
    logic       rnd_aw, rnd_w, rnd_ar;
    logic [1:0] slv_resp;
    assign AWREADY = rand_rdy ? rnd_aw : aw_rdy;
    assign WREADY  = rand_rdy ? rnd_w  : w_rdy;
    assign ARREADY = rand_rdy ? rnd_ar : ar_rdy;

    always @(negedge ACLK) begin
        rnd_aw <= ($urandom_range(0, 3) != 0);
        rnd_w  <= ($urandom_range(0, 3) != 0);
        rnd_ar <= ($urandom_range(0, 3) != 0);
    end

    logic [7:0]  mem [0:255];
    logic        mem_init, aw_got, w_got;
    logic [7:0]  aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    logic        aw_now, w_now;
    logic [7:0]  wa, ra;
    logic [31:0] wd;
    logic [3:0]  ws;
    assign aw_now = AWVALID & AWREADY;
    assign w_now  = WVALID & WREADY;
    assign wa = aw_now ? AWADDR[7:0] : aw_a;
    assign wd = w_now ? WDATA : w_d;
    assign ws = w_now ? WSTRB : w_s;
    assign ra = {ARADDR[7:2], 2'b00};

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; BVALID <= 1'b0; RVALID <= 1'b0;
            BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= '0;
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
                mem_init <= 1'b1;
            end
        end else begin
            if ((aw_got || aw_now) && (w_got || w_now)) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) mem[8'(wa + 8'(i))] <= wd[8*i +: 8];
                BVALID <= 1'b1; BRESP <= slv_resp;
                aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_now) begin aw_got <= 1'b1; aw_a <= AWADDR[7:0]; end
                if (w_now)  begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; end
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (ARVALID && ARREADY && !r_block) begin
                RVALID <= 1'b1; RRESP <= slv_resp;
                RDATA <= {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:255];

    function automatic logic [31:0] ref_read(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[8'(a + 8'(i))] = d[8*i +: 8];
    endtask

    // ---------------- bench plumbing ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [141:0] all_out;
    assign all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                      AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
                      ARVALID, ARADDR, RREADY};

    // Issue one command and collect the response; lat counts cycles from the
    // accept cycle to the first cycle with rsp_valid high (100 = never came).
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [31:0] rd,
                          output logic [1:0] rs, output logic to);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge ACLK); lat++; end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to;
        do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, lat, rd, rs, to);
        ref_write(8'h4, 32'hDEADBEEF, 4'hF);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_cmp++; if ({rs, to, rd} !== {2'b00, 1'b0, 32'h0}) begin n_err++; $display("FAIL wr_rsp: got %h want 0", {rs, to, rd}); end
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rs, to);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== ref_read(8'h4)) begin n_err++; $display("FAIL rd_data: got %h want %h", rd, ref_read(8'h4)); end
        n_cmp++; if ({rs, to} !== 3'b000) begin n_err++; $display("FAIL rd_resp: got %b want 000", {rs, to}); end
        do_cmd(1'b1, 32'h4, 32'h0000CAFE, 4'h3, lat, rd, rs, to);
        ref_write(8'h4, 32'h0000CAFE, 4'h3);
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rs, to);
        n_cmp++; if (rd !== 32'hDEADCAFE || rd !== ref_read(8'h4)) begin n_err++; $display("FAIL rd_partial: got %h want DEADCAFE", rd); end
    endtask

    task automatic test_w_delay();
        int n;
        w_rdy = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hA;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n_cmp++; if ({AWVALID, WVALID} !== 2'b11) begin n_err++; $display("FAIL wd_both_valid: got %b want 11", {AWVALID, WVALID}); end
        @(negedge ACLK);
        for (int i = 2; i <= 6; i++) begin
            n_cmp++;
            if ({AWVALID, WVALID, WDATA, WSTRB} !== {1'b0, 1'b1, 32'h12345678, 4'hA}) begin
                n_err++; $display("FAIL wd_hold_c%0d: got %h want %h", i, {AWVALID, WVALID, WDATA, WSTRB}, {1'b0, 1'b1, 32'h12345678, 4'hA});
            end
            if (i == 6) w_rdy = 1'b1;
            @(negedge ACLK);
        end
        n_cmp++; if ({WVALID, BREADY} !== 2'b01) begin n_err++; $display("FAIL wd_to_bresp: got %b want 01", {WVALID, BREADY}); end
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
        n_cmp++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b1000) begin n_err++; $display("FAIL wd_rsp: got %b want 1000", {rsp_valid, rsp_timeout, rsp_resp}); end
        @(negedge ACLK);
        ref_write(8'h20, 32'h12345678, 4'hA);
    endtask

    task automatic test_timeout();
        int n; int lat; logic [31:0] rd; logic [1:0] rs; logic to;
        aw_rdy = 1'b0; w_rdy = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hFFFF0000; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n = 0;
        while (AWVALID && n < 40) begin n++; @(negedge ACLK); end
        n_cmp++; if (n !== TMO) begin n_err++; $display("FAIL to_aw_cycles: got %0d want %0d", n, TMO); end
        n_cmp++; if ({WVALID, BREADY, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {4'b0011, 2'b10, 32'h0}) begin
            n_err++; $display("FAIL to_wr_rsp: got %h want %h", {WVALID, BREADY, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {4'b0011, 2'b10, 32'h0});
        end
        @(negedge ACLK);
        aw_rdy = 1'b1; w_rdy = 1'b1;
        r_block = 1'b1;
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, rs, to);
        r_block = 1'b0;
        n_cmp++; if (lat !== TMO + 2) begin n_err++; $display("FAIL to_rd_latency: got %0d want %0d", lat, TMO + 2); end
        n_cmp++; if ({to, rs, rd} !== {1'b1, 2'b10, 32'h0}) begin n_err++; $display("FAIL to_rd_rsp: got %h want %h", {to, rs, rd}, {1'b1, 2'b10, 32'h0}); end
        do_cmd(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, rs, to);
        n_cmp++; if ({to, rd} !== {1'b0, ref_read(8'h30)}) begin n_err++; $display("FAIL to_no_write: got %h want %h", {to, rd}, {1'b0, ref_read(8'h30)}); end
    endtask

    task automatic test_rsp_stall();
        int n; logic [34:0] snap;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
        snap = {rsp_rdata, rsp_resp, rsp_timeout};
        n_cmp++; if (snap !== {ref_read(8'h20), 2'b00, 1'b0}) begin n_err++; $display("FAIL st_first: got %h want %h", snap, {ref_read(8'h20), 2'b00, 1'b0}); end
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout} !== {2'b10, snap}) begin
                n_err++; $display("FAIL st_hold_%0d: got %h want %h", i, {rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout}, {2'b10, snap});
            end
        end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL st_release: got %b want 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, d, exp_rd; logic [1:0] rs; logic to, wr; logic [3:0] s; logic [7:0] a;
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 15) * 4);
            d = $urandom; s = 4'($urandom_range(0, 15)); slv_resp = 2'($urandom_range(0, 3));
            exp_rd = wr ? 32'h0 : ref_read(a);
            do_cmd(wr, {24'h0, a}, d, s, lat, rd, rs, to);
            if (wr) ref_write(a, d, s);
            n_cmp++;
            if ({lat < 100, to, rs, rd} !== {1'b1, 1'b0, slv_resp, exp_rd}) begin
                n_err++; $display("FAIL rnd_%0d: got %h want %h", i, {lat < 100, to, rs, rd}, {1'b1, 1'b0, slv_resp, exp_rd});
            end
        end
        rand_rdy = 1'b0; slv_resp = 2'b00;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to;
        r_block = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        n_cmp++; if (RREADY !== 1'b1) begin n_err++; $display("FAIL rm_in_rd_resp: got %b want 1", RREADY); end
        #2 ARESETN = 1'b0;
        #1;
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL rm_outputs: got %h want 0", all_out); end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1; r_block = 1'b0;
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rs, to);
        n_cmp++; if ({lat, to, rs, rd} !== {32'd3, 1'b0, 2'b00, ref_read(8'h4)}) begin
            n_err++; $display("FAIL rm_next_read: got %h want %h", {lat, to, rs, rd}, {32'd3, 1'b0, 2'b00, ref_read(8'h4)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        mem_init = 1'b0;
        ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; r_block = 1'b0;
        rand_rdy = 1'b0; slv_resp = 2'b00;
        test_reset();
        test_write_read();
        test_w_delay();
        test_timeout();
        test_rsp_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
